// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the register-file write port: ALU writeback (A) vs load/link writeback (B).
// Optional WBARB_ZERO_SUPPRESS_EN: transfers to $zero are granted but never raise RegWrite.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              ReqA,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DataA,
  output logic              GntA,
  input  logic              ReqB,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] DataB,
  output logic              GntB,
  input  logic              Stall,
  output logic              Sel,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises Req with Addr/Data stable and holds them until it
  // sees Gnt; a transfer happens on any rising edge where Req and Gnt are both high.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAST_A = 2'd1,
    LAST_B = 2'd2
  } state_t;

  state_t state, next_state;
  logic   load_a, load_b;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Grants are gated by Reset_n so they drop immediately when reset asserts.
  always_comb begin
    GntA       = 1'b0;
    GntB       = 1'b0;
    next_state = state;
    if (Reset_n && !Stall) begin
      if (ReqA && ReqB) begin
        if (state == LAST_A) GntB = 1'b1;
        else                 GntA = 1'b1;
      end else begin
        GntA = ReqA;
        GntB = ReqB;
      end
    end
    if (GntA)      next_state = LAST_A;
    else if (GntB) next_state = LAST_B;
  end

`ifdef WBARB_ZERO_SUPPRESS_EN
  assign load_a = GntA && (AddrA != '0);
  assign load_b = GntB && (AddrB != '0);
`else
  assign load_a = GntA;
  assign load_b = GntB;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Sel       <= 1'b0;
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= load_a || load_b;
      if (load_a) begin
        Sel       <= 1'b0;
        WriteAddr <= AddrA;
        WriteData <= DataA;
      end else if (load_b) begin
        Sel       <= 1'b1;
        WriteAddr <= AddrB;
        WriteData <= DataB;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Two-requester arbiter for the single register-file write port of the MIPS datapath. It chooses between the ALU writeback source (A) and the load/link writeback source (B) with round-robin priority and a valid/grant handshake. It drives the 5-bit destination-select line (same polarity as the 2:1 5-bit destination mux) and registers the winning address and data onto the write port.

## Interface

Parameters:
- DATA_W, 32, width of write data
- ADDR_W, 5, width of register address

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReqA  in  1  requester A has a write pending
- AddrA  in  ADDR_W  destination register, requester A
- DataA  in  DATA_W  write data, requester A
- GntA  out  1  A transfers this cycle (combinational)
- ReqB  in  1  requester B has a write pending
- AddrB  in  ADDR_W  destination register, requester B
- DataB  in  DATA_W  write data, requester B
- GntB  out  1  B transfers this cycle (combinational)
- Stall  in  1  write port unavailable; blocks new grants
- Sel  out  1  source of the current write: 0 = A (D1 side), 1 = B (D2 side)
- RegWrite  out  1  write-enable to the register file
- WriteAddr  out  ADDR_W  registered destination address
- WriteData  out  DATA_W  registered write data

## Operation

- FSM states: IDLE (reset; A has priority), LAST_A (B has priority), LAST_B (A has priority).
- Grant logic:
  - Stall=1: GntA=GntB=0.
  - Otherwise, a single requester is granted.
  - If both request, the priority side is granted.
  - GntA and GntB are never both 1.
- Transfer: Req&Gnt high at a rising edge. Requesters hold Req, Addr and Data stable until they see Gnt. Req may drop only after a transfer.
- On a transfer from X:
  - state becomes LAST_X;
  - WriteAddr and WriteData are loaded from X;
  - Sel is set to X (A=0, B=1);
  - RegWrite is set to 1.
- No transfer:
  - state is unchanged;
  - RegWrite is cleared to 0;
  - Sel, WriteAddr and WriteData hold their values.
- Back-to-back transfers are allowed every cycle. With both requesting continuously, grants alternate A, B, A, B…
- Reset values: state IDLE, GntA=GntB=0, Sel=0, RegWrite=0, WriteAddr=0, WriteData=0.
- Reset asserted mid-operation:
  - outputs clear asynchronously and immediately;
  - a pending un-granted request is not lost from the requester's side; it stays asserted and is granted after reset releases;
  - a write registered but not yet consumed is dropped.

## Timing

- Grant: zero-cycle, combinational from ReqA, ReqB, Stall and state.
- Latency from transfer edge to RegWrite/WriteAddr/WriteData valid: 1 cycle.
- RegWrite is high for exactly one cycle per transfer.
- Stall rising: takes effect in the same cycle. The write registered in the previous cycle still presents on RegWrite.
- Stall falling: a grant is possible in the same cycle.
- No combinational path from any input to RegWrite, WriteAddr, WriteData or Sel.

## Configuration

- Macro WBARB_ZERO_SUPPRESS_EN.
- Defined:
  - a transfer with address 0 ($zero) is granted and advances the FSM;
  - RegWrite stays 0 in the following cycle;
  - WriteAddr, WriteData and Sel hold their previous values.
- Undefined: address 0 is treated like any other address, so RegWrite=1 and the outputs load.

## Test plan

- Reset, then ReqA=1, AddrA=5'd8, DataA=32'h1234, ReqB=0 -> GntA=1 in that cycle. Next cycle: RegWrite=1, WriteAddr=8, WriteData=32'h1234, Sel=0.
- ReqA and ReqB held high for 4 cycles, AddrA=3, AddrB=17 -> grants A,B,A,B. WriteAddr sequence 3,17,3,17 one cycle later; Sel 0,1,0,1; RegWrite continuously 1.
- ReqB=1 with Stall=1 for 3 cycles, then Stall=0 -> GntB=0 while stalled, RegWrite=0. GntB=1 on the first unstalled cycle; RegWrite=1 with Sel=1 the next cycle.
- Transfer from A, then only ReqB on the next cycle -> GntB=1 immediately, with no idle bubble between the two writes.
- ReqA=1, AddrA=0, DataA=32'hFFFF -> with WBARB_ZERO_SUPPRESS_EN: GntA=1, next-cycle RegWrite=0, WriteAddr unchanged. Without the macro: RegWrite=1, WriteAddr=0.
- Reset_n pulled low mid-burst (both requesting) -> RegWrite, Sel, WriteAddr and WriteData are 0 before the next edge, and Gnt is 0. After release the first grant goes to A (IDLE priority).
